wb_mem_responder: RTL and testbench

WB_MEM_RESPONDER -- requirements
Module: wb_mem_responder

---
 rtl/wb_mem_responder.sv | 199 +++++++++++++++++++
 tb/tb_wb_mem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_responder.sv
// wb_mem_responder: pipelined Wishbone slave backed by a 32-bit word RAM.
// Accepted requests queue in a 2-entry FIFO. A head FSM inserts WAIT_STATES
// idle cycles before each single-cycle response.
// Optional feature: define WB_RESP_ADDR_ERR_EN to answer requests whose address
// bits above the RAM range are nonzero with wb_err_o instead of wb_ack_o.
module wb_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 0,
  parameter              MEMORY_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_addr_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] wb_data_o,
  output logic        wb_ack_o,
  output logic        wb_stall_o,
  output logic        wb_err_o
);

  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
  localparam int unsigned WAIT_W = 4;
  localparam logic [WAIT_W-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? WAIT_W'(WAIT_STATES - 1) : '0;

  // One queued Wishbone request
  typedef struct packed {
    logic                  we;
    logic                  err;
    logic [3:0]            sel;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           data;
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  req_t                fifo_q [2];
  logic                rd_ptr_q, wr_ptr_q;
  logic [1:0]          count_q;

  logic [31:0]         mem [DEPTH];
  logic [31:0]         rd_word;
  logic [31:0]         data_q;
  logic                ack_q, err_q;

  req_t                in_req;
  req_t                cand;
  logic                accept;
  logic                skip;
  logic [1:0]          avail;
  logic                cand_valid;
  logic                pop;
  logic                resp_enter;
  logic                ram_we;
  logic                unused_addr;

  // Incoming request, tagged with an address-range error when enabled
  always_comb begin
    in_req.we   = wb_we_i;
    in_req.sel  = wb_sel_i;
    in_req.idx  = wb_addr_i[ADDR_WIDTH+1:2];
    in_req.data = wb_data_i;
`ifdef WB_RESP_ADDR_ERR_EN
    in_req.err  = |wb_addr_i[31:ADDR_WIDTH+2];
`else
    in_req.err  = 1'b0;
`endif
  end

  assign unused_addr = ^{wb_addr_i[31:ADDR_WIDTH+2], wb_addr_i[1:0]};

  // A full FIFO stalls unless its head is being answered this cycle
  assign wb_stall_o = (count_q == 2'd2) && (state_q != S_RESP);
  assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  assign pop        = (state_q == S_RESP);

  // Entry served next: the head, skipping one being answered now, else the bypassed input
  always_comb begin
    skip       = (state_q == S_RESP);
    avail      = count_q - 2'(skip);
    cand_valid = (avail != 2'd0) | accept;
    cand       = (avail != 2'd0) ? fifo_q[rd_ptr_q ^ skip] : in_req;
  end

  // Head FSM next-state and wait counter
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    if (!wb_cyc_i) begin
      state_d = S_IDLE;
      wait_d  = '0;
    end else begin
      case (state_q)
        S_IDLE, S_RESP: begin
          if (cand_valid) begin
            if (WAIT_STATES > 0) begin
              state_d = S_WAIT;
              wait_d  = WAIT_LOAD;
            end else begin
              state_d = S_RESP;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WAIT: begin
          if (wait_q == '0) begin
            state_d = S_RESP;
          end else begin
            wait_d = wait_q - WAIT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          wait_d  = '0;
        end
      endcase
    end
  end

  // Each cycle spent in RESP answers exactly one entry
  assign resp_enter = (state_d == S_RESP);
  assign ram_we     = resp_enter & cand.we & ~cand.err & ~rst;
  assign rd_word    = mem[cand.idx];

  // Head FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Request FIFO; dropping wb_cyc_i discards everything queued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else if (!wb_cyc_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (accept) begin
        fifo_q[wr_ptr_q] <= in_req;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(accept) - 2'(pop);
    end
  end

  // Registered response: ack or err pulse, read data only on read acks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      data_q <= '0;
    end else begin
      ack_q  <= resp_enter & ~cand.err;
      err_q  <= resp_enter & cand.err;
      data_q <= (resp_enter & ~cand.we & ~cand.err) ? rd_word : 32'd0;
    end
  end

  // Byte-lane RAM write, committed as the write enters its response cycle
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (cand.sel[b]) begin
          mem[cand.idx][8*b +: 8] <= cand.data[8*b +: 8];
        end
      end
    end
  end

  assign wb_ack_o  = ack_q;
  assign wb_err_o  = err_q;
  assign wb_data_o = data_q;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench: instance 0 has no wait states, instance 1 has three.
module tb_wb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc   [2];
  logic        stb   [2];
  logic        we;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata [2];
  logic        ack   [2];
  logic        stall [2];
  logic        err   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we),
    .wb_sel_i(sel), .wb_addr_i(addr), .wb_data_i(wdata),
    .wb_data_o(rdata[0]), .wb_ack_o(ack[0]), .wb_stall_o(stall[0]), .wb_err_o(err[0])
  );

  wb_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we),
    .wb_sel_i(sel), .wb_addr_i(addr), .wb_data_i(wdata),
    .wb_data_o(rdata[1]), .wb_ack_o(ack[1]), .wb_stall_o(stall[1]), .wb_err_o(err[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single transfer on instance d; lat counts cycles from acceptance to response
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] dat,
                      input logic [3:0] s, input logic exp_ack, input logic exp_err,
                      input logic [31:0] exp_dat, input int exp_lat, input string tag);
    int lat;
    cyc[d] = 1'b1;
    stb[d] = 1'b1;
    we     = w;
    addr   = a;
    wdata  = dat;
    sel    = s;
    chk({tag, " stall"}, 32'(stall[d]), 32'd0);
    tick();
    stb[d] = 1'b0;
    we     = 1'b0;
    lat    = 0;
    while (!(ack[d] || err[d]) && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, " lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, " ack"}, 32'(ack[d]), 32'(exp_ack));
    chk({tag, " err"}, 32'(err[d]), 32'(exp_err));
    chk({tag, " data"}, rdata[d], exp_dat);
    tick();
    chk({tag, " pulse"}, 32'({ack[d], err[d]}), 32'd0);
  endtask

  task automatic chk_idle(input int d, input string tag);
    chk({tag, " ack"}, 32'(ack[d]), 32'd0);
    chk({tag, " err"}, 32'(err[d]), 32'd0);
    chk({tag, " stall"}, 32'(stall[d]), 32'd0);
    chk({tag, " data"}, rdata[d], 32'd0);
  endtask

  initial begin
    int          acks;
    int          acc_edge;
    int          n;
    logic        wacc;
    logic [31:0] exp_rd [3];
    logic [31:0] exp_w0;
    int          exp_e  [3];

    rst = 1'b1;
    cyc[0] = 1'b0; cyc[1] = 1'b0;
    stb[0] = 1'b0; stb[1] = 1'b0;
    we = 1'b0; sel = 4'h0; addr = '0; wdata = '0;
    tick();
    tick();
    // Requests presented during reset must be ignored
    cyc[0] = 1'b1; cyc[1] = 1'b1;
    stb[0] = 1'b1; stb[1] = 1'b1;
    tick();
    tick();
    chk_idle(0, "reset d0");
    chk_idle(1, "reset d3");
    stb[0] = 1'b0; stb[1] = 1'b0;
    cyc[0] = 1'b0; cyc[1] = 1'b0;
    rst = 1'b0;
    tick();
    chk_idle(0, "post reset d0");

    // Back-to-back write then read, no wait states
    cyc[0] = 1'b1; stb[0] = 1'b1; we = 1'b1; addr = 32'h10;
    wdata = 32'hDEADBEEF; sel = 4'hF;
    tick();
    chk("b2b wr ack", 32'(ack[0]), 32'd1);
    chk("b2b wr data", rdata[0], 32'd0);
    we = 1'b0; wdata = '0;
    tick();
    chk("b2b rd ack", 32'(ack[0]), 32'd1);
    chk("b2b rd data", rdata[0], 32'hDEADBEEF);
    stb[0] = 1'b0;
    tick();
    chk("b2b end ack", 32'(ack[0]), 32'd0);

    // Byte-lane merge and empty-select write
    xfer(0, 1'b1, 32'h80, 32'h11223344, 4'hF, 1'b1, 1'b0, 32'h0, 0, "w20 init");
    xfer(0, 1'b1, 32'h80, 32'hAABBCCDD, 4'h5, 1'b1, 1'b0, 32'h0, 0, "w20 lanes");
    xfer(0, 1'b0, 32'h80, 32'h0, 4'hF, 1'b1, 1'b0, 32'h11BB33DD, 0, "w20 rd");
    xfer(0, 1'b1, 32'h80, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b0, 32'h0, 0, "sel0 wr");
    xfer(0, 1'b0, 32'h80, 32'h0, 4'hF, 1'b1, 1'b0, 32'h11BB33DD, 0, "sel0 rd");

    // Out-of-range address: error response or aliasing onto word 0
    xfer(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 32'h0, 0, "w0 init");
`ifdef WB_RESP_ADDR_ERR_EN
    xfer(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, 1'b0, 1'b1, 32'h0, 0, "oor wr");
    exp_w0 = 32'hCAFEF00D;
`else
    xfer(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, 1'b1, 1'b0, 32'h0, 0, "oor wr");
    exp_w0 = 32'h12345678;
`endif
    xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b1, 1'b0, exp_w0, 0, "w0 rd");

    // Three wait states: preload then three back-to-back reads
    xfer(1, 1'b1, 32'h4, 32'hA1A1A1A1, 4'hF, 1'b1, 1'b0, 32'h0, 3, "pre1");
    xfer(1, 1'b1, 32'h8, 32'hA2A2A2A2, 4'hF, 1'b1, 1'b0, 32'h0, 3, "pre2");
    xfer(1, 1'b1, 32'hC, 32'hA3A3A3A3, 4'hF, 1'b1, 1'b0, 32'h0, 3, "pre3");
    exp_rd[0] = 32'hA1A1A1A1; exp_rd[1] = 32'hA2A2A2A2; exp_rd[2] = 32'hA3A3A3A3;
    exp_e[0] = 3; exp_e[1] = 7; exp_e[2] = 11;
    cyc[1] = 1'b1; stb[1] = 1'b1; we = 1'b0; sel = 4'hF; addr = 32'h4;
    tick();
    chk("q1 stall", 32'(stall[1]), 32'd0);
    addr = 32'h8;
    tick();
    chk("q2 stall", 32'(stall[1]), 32'd1);
    addr = 32'hC;
    acks = 0;
    acc_edge = -1;
    for (int c = 2; c <= 13; c++) begin
      wacc = stb[1] && !stall[1];
      tick();
      if (wacc) begin
        acc_edge = c;
        stb[1] = 1'b0;
      end
      if (ack[1]) begin
        if (acks < 3) begin
          chk("q ack edge", 32'(c), 32'(exp_e[acks]));
          chk("q ack data", rdata[1], exp_rd[acks]);
        end
        acks++;
      end
    end
    stb[1] = 1'b0;
    chk("q ack count", 32'(acks), 32'd3);
    chk("q third accept", 32'(acc_edge), 32'd4);

    // Dropping wb_cyc_i with two requests queued
    xfer(1, 1'b1, 32'h14, 32'h55555555, 4'hF, 1'b1, 1'b0, 32'h0, 3, "pre5");
    cyc[1] = 1'b1; stb[1] = 1'b1; we = 1'b1; addr = 32'h14; wdata = 32'hFFFFFFFF;
    tick();
    we = 1'b0;
    tick();
    chk("flush full", 32'(stall[1]), 32'd1);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ack[1] || err[1]) n++;
    end
    chk("flush no ack", 32'(n), 32'd0);
    chk("flush stall", 32'(stall[1]), 32'd0);
    xfer(1, 1'b0, 32'h14, 32'h0, 4'hF, 1'b1, 1'b0, 32'h55555555, 3, "flush rd");

    // Reset pulse while a write sits in WAIT
    xfer(1, 1'b1, 32'h18, 32'h66666666, 4'hF, 1'b1, 1'b0, 32'h0, 3, "pre6");
    stb[1] = 1'b1; we = 1'b1; addr = 32'h18; wdata = 32'h99999999;
    tick();
    stb[1] = 1'b0; we = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk_idle(1, "rst mid d3");
    tick();
    tick();
    rst = 1'b0;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ack[1] || err[1]) n++;
    end
    chk("rst no ack", 32'(n), 32'd0);
    xfer(1, 1'b0, 32'h18, 32'h0, 4'hF, 1'b1, 1'b0, 32'h66666666, 3, "rst rd");
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 1'b0, 32'hDEADBEEF, 0, "ram keep");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
